// File: rtl/axi_rd_arbiter.sv
// Per-slave AXI read-address arbiter: picks one master's AR request (round-robin or
// fixed priority), forwards it with the master index prepended to ARID, and holds the grant until RLAST.
module axi_rd_arbiter #(
    parameter int NUM_M     = 2,
    parameter int ID_BITS   = 4,
    parameter int MIDX_BITS = 4,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 3,
    localparam int IDS_BITS = MIDX_BITS + ID_BITS
) (
    input  logic                       AXI_CLK_i,
    input  logic                       AXI_RST_i,
    input  logic                       MODE_i,
    input  logic [NUM_M*ID_BITS-1:0]   ARID_M_i,
    input  logic [NUM_M*ADDR_BITS-1:0] ARADDR_M_i,
    input  logic [NUM_M*LEN_BITS-1:0]  ARLEN_M_i,
    input  logic [NUM_M*SIZE_BITS-1:0] ARSIZE_M_i,
    input  logic [NUM_M*2-1:0]         ARBURST_M_i,
    input  logic [NUM_M-1:0]           ARVALID_M_i,
    output logic [NUM_M-1:0]           ARREADY_M_o,
    output logic [IDS_BITS-1:0]        ARID_S_o,
    output logic [ADDR_BITS-1:0]       ARADDR_S_o,
    output logic [LEN_BITS-1:0]        ARLEN_S_o,
    output logic [SIZE_BITS-1:0]       ARSIZE_S_o,
    output logic [1:0]                 ARBURST_S_o,
    output logic                       ARVALID_S_o,
    input  logic                       ARREADY_S_i,
    input  logic [IDS_BITS-1:0]        RID_S_i,
    input  logic                       RVALID_S_i,
    input  logic                       RREADY_S_i,
    input  logic                       RLAST_S_i,
    output logic [NUM_M-1:0]           GRANT_o,
    output logic                       BUSY_o
);

    localparam int PTR_BITS = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e                 state_q, state_d;
    logic [PTR_BITS-1:0]    ptr_q, ptr_d;
    logic [PTR_BITS-1:0]    owner_q, owner_d;
    logic [IDS_BITS-1:0]    arId_q;
    logic [ADDR_BITS-1:0]   arAddr_q;
    logic [LEN_BITS-1:0]    arLen_q;
    logic [SIZE_BITS-1:0]   arSize_q;
    logic [1:0]             arBurst_q;

    logic                   winValid;
    logic [PTR_BITS-1:0]    winIdx;
    logic [PTR_BITS-1:0]    candIdx;
    logic                   grantFire;
    logic                   rdDone;
    logic                   unusedRidLow;

    // Only the master-index field of RID identifies the owner; the master's own ID bits are don't-care here.
    assign unusedRidLow = ^RID_S_i[ID_BITS-1:0];

    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            candIdx = MODE_i ? PTR_BITS'(i) : PTR_BITS'((int'(ptr_q) + i) % NUM_M);
            if (!winValid && ARVALID_M_i[candIdx]) begin
                winValid = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    assign grantFire = (state_q == IDLE) && winValid;
    assign rdDone    = RVALID_S_i && RREADY_S_i && RLAST_S_i &&
                       (RID_S_i[IDS_BITS-1:ID_BITS] == MIDX_BITS'(owner_q));

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    state_d = ADDR;
                    owner_d = winIdx;
                    ptr_d   = (winIdx == PTR_BITS'(NUM_M - 1)) ? '0 : winIdx + PTR_BITS'(1);
                end
            end
            ADDR: begin
                if (ARREADY_S_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rdDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ARREADY is gated by reset so a request present during reset is never acknowledged.
    always_comb begin
        ARREADY_M_o = '0;
        GRANT_o     = '0;
        ARVALID_S_o = (state_q == ADDR);
        BUSY_o      = (state_q != IDLE);
        if (AXI_RST_i && grantFire) begin
            ARREADY_M_o[winIdx] = 1'b1;
        end
        if (state_q != IDLE) begin
            GRANT_o[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            arId_q    <= '0;
            arAddr_q  <= '0;
            arLen_q   <= '0;
            arSize_q  <= '0;
            arBurst_q <= '0;
        end else if (grantFire) begin
            arId_q    <= {MIDX_BITS'(winIdx), ARID_M_i[winIdx*ID_BITS +: ID_BITS]};
            arAddr_q  <= ARADDR_M_i[winIdx*ADDR_BITS +: ADDR_BITS];
            arLen_q   <= ARLEN_M_i[winIdx*LEN_BITS +: LEN_BITS];
            arSize_q  <= ARSIZE_M_i[winIdx*SIZE_BITS +: SIZE_BITS];
            arBurst_q <= ARBURST_M_i[winIdx*2 +: 2];
        end
    end

    assign ARID_S_o    = arId_q;
    assign ARADDR_S_o  = arAddr_q;
    assign ARLEN_S_o   = arLen_q;
    assign ARSIZE_S_o  = arSize_q;
    assign ARBURST_S_o = arBurst_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (4 masters): a transaction-level model of the arbiter is
// compared against the DUT every cycle, with directed scenarios pinned by literal expectations.
module tb_axi_rd_arbiter;

    localparam int NM   = 4;
    localparam int IDB  = 4;
    localparam int MIB  = 4;
    localparam int AB   = 32;
    localparam int LB   = 4;
    localparam int SB   = 3;
    localparam int IDSB = MIB + IDB;

    logic               clk  = 1'b0;
    logic               rstN = 1'b0;
    logic               mode;
    logic [NM*IDB-1:0]  aridBus;
    logic [NM*AB-1:0]   araddrBus;
    logic [NM*LB-1:0]   arlenBus;
    logic [NM*SB-1:0]   arsizeBus;
    logic [NM*2-1:0]    arburstBus;
    logic [NM-1:0]      arvalidM;
    logic [NM-1:0]      arreadyM;
    logic [IDSB-1:0]    aridS;
    logic [AB-1:0]      araddrS;
    logic [LB-1:0]      arlenS;
    logic [SB-1:0]      arsizeS;
    logic [1:0]         arburstS;
    logic               arvalidS;
    logic               arreadyS;
    logic [IDSB-1:0]    rid;
    logic               rvalid;
    logic               rready;
    logic               rlast;
    logic [NM-1:0]      grant;
    logic               busy;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .NUM_M(NM), .ID_BITS(IDB), .MIDX_BITS(MIB),
        .ADDR_BITS(AB), .LEN_BITS(LB), .SIZE_BITS(SB)
    ) dut (
        .AXI_CLK_i(clk), .AXI_RST_i(rstN), .MODE_i(mode),
        .ARID_M_i(aridBus), .ARADDR_M_i(araddrBus), .ARLEN_M_i(arlenBus),
        .ARSIZE_M_i(arsizeBus), .ARBURST_M_i(arburstBus), .ARVALID_M_i(arvalidM),
        .ARREADY_M_o(arreadyM),
        .ARID_S_o(aridS), .ARADDR_S_o(araddrS), .ARLEN_S_o(arlenS),
        .ARSIZE_S_o(arsizeS), .ARBURST_S_o(arburstS), .ARVALID_S_o(arvalidS),
        .ARREADY_S_i(arreadyS),
        .RID_S_i(rid), .RVALID_S_i(rvalid), .RREADY_S_i(rready), .RLAST_S_i(rlast),
        .GRANT_o(grant), .BUSY_o(busy)
    );

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one outstanding burst, tracked as "waiting for slave accept" and "waiting for RLAST".
    bit             mBusy;
    bit             mAddr;
    int             mOwner;
    int             mPtr;
    logic [IDSB-1:0] mId;
    logic [AB-1:0]  mAddrF;
    logic [LB-1:0]  mLen;
    logic [SB-1:0]  mSize;
    logic [1:0]     mBurst;
    int             mdlWin;
    int             cmpWin;
    logic [NM-1:0]  expArready;
    logic [NM-1:0]  expGrant;
    logic [NM-1:0]  grantLog[$];

    function automatic int pickWinner(input logic [NM-1:0] v, input logic m, input int p);
        int c;
        for (int i = 0; i < NM; i++) begin
            c = m ? i : (p + i) % NM;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic resetModel();
        mBusy = 0; mAddr = 0; mOwner = 0; mPtr = 0;
        mId = '0; mAddrF = '0; mLen = '0; mSize = '0; mBurst = '0;
    endtask

    always @(negedge rstN) resetModel();

    always @(posedge clk) begin
        if (rstN) begin
            if (!mBusy) begin
                mdlWin = pickWinner(arvalidM, mode, mPtr);
                if (mdlWin >= 0) begin
                    mOwner = mdlWin;
                    mPtr   = (mdlWin + 1) % NM;
                    mBusy  = 1;
                    mAddr  = 1;
                    mId    = {4'(mdlWin), aridBus[mdlWin*IDB +: IDB]};
                    mAddrF = araddrBus[mdlWin*AB +: AB];
                    mLen   = arlenBus[mdlWin*LB +: LB];
                    mSize  = arsizeBus[mdlWin*SB +: SB];
                    mBurst = arburstBus[mdlWin*2 +: 2];
                end
            end else if (mAddr) begin
                if (arreadyS) mAddr = 0;
            end else if (rvalid && rready && rlast && rid[IDSB-1:IDB] == 4'(mOwner)) begin
                mBusy = 0;
            end
        end
    end

    always @(negedge clk) begin
        expArready = '0;
        if (rstN && !mBusy) begin
            cmpWin = pickWinner(arvalidM, mode, mPtr);
            if (cmpWin >= 0) expArready[cmpWin] = 1'b1;
        end
        expGrant = mBusy ? 4'(1 << mOwner) : 4'd0;
        checkOutput("arreadyM", arreadyM, expArready);
        checkOutput("grant",    grant,    expGrant);
        checkOutput("busy",     busy,     mBusy);
        checkOutput("arvalidS", arvalidS, mAddr);
        checkOutput("aridS",    aridS,    mId);
        checkOutput("araddrS",  araddrS,  mAddrF);
        checkOutput("arlenS",   arlenS,   mLen);
        checkOutput("arsizeS",  arsizeS,  mSize);
        checkOutput("arburstS", arburstS, mBurst);
        if (arreadyM != '0) grantLog.push_back(arreadyM);
    end

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic randomizeFields();
        aridBus    = 16'($urandom);
        araddrBus  = {$urandom, $urandom, $urandom, $urandom};
        arlenBus   = 16'($urandom);
        arsizeBus  = 12'($urandom);
        arburstBus = 8'($urandom);
    endtask

    task automatic quietSlave();
        arreadyS = 0; rvalid = 0; rready = 0; rlast = 0; rid = '0;
    endtask

    task automatic fullSlave();
        arreadyS = 1; rvalid = 1; rready = 1; rlast = 1; rid = {4'(mOwner), 4'h0};
    endtask

    task automatic drainToIdle();
        arvalidM = '0;
        for (int i = 0; i < 20 && busy; i++) begin
            fullSlave();
            applyStimulus(1);
        end
        quietSlave();
        checkOutput("drainIdle", busy, 1'b0);
    endtask

    logic [NM-1:0] rrOrder[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [AB-1:0] addr0;
    logic [IDSB-1:0] id0;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetModel();
        quietSlave();
        mode = 0;
        arvalidM = '0;
        randomizeFields();
        #1;
        checkOutput("rstGrant", grant, 4'b0);
        checkOutput("rstBusy",  busy,  1'b0);
        repeat (3) @(posedge clk);
        #3 rstN = 1;
        applyStimulus(1);

        // Round-robin with all masters requesting and an always-ready single-beat slave.
        mode = 0;
        arvalidM = 4'b1111;
        grantLog.delete();
        for (int c = 0; c < 15; c++) begin
            fullSlave();
            randomizeFields();
            applyStimulus(1);
        end
        checkOutput("rrCount", grantLog.size(), 5);
        for (int i = 0; i < 5 && i < grantLog.size(); i++) begin
            checkOutput($sformatf("rrOrder%0d", i), grantLog[i], rrOrder[i]);
            checkOutput($sformatf("rrOneHot%0d", i), $countones(grantLog[i]), 1);
        end
        drainToIdle();

        // Fixed priority: master 1 always beats master 3.
        mode = 1;
        arvalidM = 4'b1010;
        grantLog.delete();
        for (int c = 0; c < 12; c++) begin
            fullSlave();
            applyStimulus(1);
        end
        checkOutput("fpCount", grantLog.size(), 4);
        for (int i = 0; i < grantLog.size(); i++)
            checkOutput($sformatf("fpGrant%0d", i), grantLog[i], 4'b0010);
        drainToIdle();

        // ID tagging and RID matching for master 2.
        mode = 0;
        quietSlave();
        randomizeFields();
        aridBus[8 +: 4]  = 4'h5;
        arlenBus[8 +: 4] = 4'd3;
        arvalidM = 4'b0100;
        applyStimulus(1);
        checkOutput("idTag", aridS, 8'h25);
        checkOutput("idLen", arlenS, 4'd3);
        arvalidM = '0;
        arreadyS = 1;
        applyStimulus(1);
        arreadyS = 0;
        rvalid = 1; rready = 1; rlast = 1; rid = 8'h15;
        applyStimulus(1);
        checkOutput("foreignRlast", grant, 4'b0100);
        for (int b = 0; b < 4; b++) begin
            rid = 8'h25;
            rlast = (b == 3);
            applyStimulus(1);
            if (b < 3) checkOutput($sformatf("beatHold%0d", b), grant, 4'b0100);
        end
        checkOutput("releaseGrant", grant, 4'b0000);
        quietSlave();
        drainToIdle();

        // Slave backpressure: AR held stable for 5 cycles while others wait.
        randomizeFields();
        addr0 = araddrBus[31:0];
        id0   = {4'h0, aridBus[3:0]};
        arvalidM = 4'b0001;
        applyStimulus(1);
        arvalidM = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bpValid%0d", k), arvalidS, 1'b1);
            checkOutput($sformatf("bpAddr%0d", k),  araddrS, addr0);
            checkOutput($sformatf("bpId%0d", k),    aridS, id0);
            checkOutput($sformatf("bpReady%0d", k), arreadyM, 4'b0000);
            checkOutput($sformatf("bpGrant%0d", k), grant, 4'b0001);
            randomizeFields();
            applyStimulus(1);
        end
        arreadyS = 1;
        applyStimulus(1);
        checkOutput("bpAccepted", arvalidS, 1'b0);
        drainToIdle();

        // Mode switch during DATA: grant finishes, next arbitration is round-robin from ptr=2.
        mode = 1;
        arvalidM = 4'b0010;
        applyStimulus(1);
        arvalidM = '0;
        arreadyS = 1;
        applyStimulus(1);
        arreadyS = 0;
        mode = 0;
        arvalidM = 4'b1010;
        rvalid = 1; rready = 1; rlast = 1; rid = 8'h10;
        applyStimulus(1);
        quietSlave();
        #1;
        checkOutput("msIdle", grant, 4'b0000);
        checkOutput("msNewMode", arreadyM, 4'b1000);
        applyStimulus(1);
        checkOutput("msGrant", grant, 4'b1000);
        drainToIdle();

        // Asynchronous reset while master 1 owns the slave in DATA.
        mode = 0;
        arvalidM = 4'b0010;
        applyStimulus(1);
        arvalidM = '0;
        arreadyS = 1;
        applyStimulus(1);
        arreadyS = 0;
        checkOutput("preRstBusy", busy, 1'b1);
        #2 rstN = 0;
        #1;
        checkOutput("rstMidGrant",   grant,    4'b0000);
        checkOutput("rstMidBusy",    busy,     1'b0);
        checkOutput("rstMidArvalid", arvalidS, 1'b0);
        checkOutput("rstMidArid",    aridS,    8'h00);
        checkOutput("rstMidAraddr",  araddrS,  32'h0);
        arvalidM = 4'b0011;
        #1;
        checkOutput("rstMidArready", arreadyM, 4'b0000);
        #2 rstN = 1;
        #1;
        checkOutput("postRstArready", arreadyM, 4'b0001);
        applyStimulus(1);
        checkOutput("postRstGrant", grant, 4'b0001);
        drainToIdle();

        // Randomized traffic with occasional mid-cycle resets.
        for (int c = 0; c < 800; c++) begin
            randomizeFields();
            arvalidM = 4'($urandom);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            arreadyS = 1'($urandom_range(0, 1));
            rvalid   = 1'($urandom_range(0, 1));
            rready   = 1'($urandom_range(0, 3) != 0);
            rlast    = ($urandom_range(0, 2) == 0);
            rid      = $urandom_range(0, 1) ? {4'(mOwner), 4'($urandom)} : 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #1 rstN = 0;
                #1 rstN = 1;
            end
            applyStimulus(1);
        end
        drainToIdle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
